// File: rtl/addsub_serial.sv
// -----------------------------------------------------------------------------
// addsub_serial
//
// Multi-cycle add/subtract unit (ADD, ADC, SUB, SBC) that processes CHUNK
// bits per clock. The carry between chunks is registered, so the longest
// carry chain is CHUNK bits instead of WIDTH bits. The unit returns the
// result with ARM-style N/Z/C/V flags. It has valid/ready handshakes on the
// operand side and on the result side.
//
// Parameters
//   WIDTH      operand/result width (must be a multiple of CHUNK)
//   CHUNK      bits computed per RUN cycle
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   a/b/c_in/op are valid this cycle
//   in_ready   block can accept an operation (IDLE only)
//   a, b       operands
//   c_in       carry input, used by ADC and SBC
//   op         00 ADD, 01 ADC, 10 SUB, 11 SBC
//   out_valid  s and flags are valid (DONE only)
//   out_ready  consumer takes the result
//   s          result
//   n, z, c, v negative, zero, carry (1 = no borrow on subtract), overflow
// -----------------------------------------------------------------------------
module addsub_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("addsub_serial: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [WIDTH-1:0]   a_q, bx_q, s_q, s_d;
    logic [CNT_W-1:0]   count_q;
    logic               carry_q;
    logic               n_q, z_q, c_q, v_q;

    logic [CHUNK-1:0]   a_slice, bx_slice;
    logic [CHUNK:0]     sum;
    logic               last;

    assign last = (count_q == CNT_W'(NCH - 1));

    // ---------------------------------------------------------------- FSM --
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so that no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)  state_d = RUN;
            RUN:  if (last)      state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // The handshake outputs decode the state register only, so no input
    // reaches them combinationally.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // ----------------------------------------------------------- datapath --
    // Select the current chunk and write its sum back into a copy of s. The
    // loop compares against constant indices, so every part-select is fixed.
    always_comb begin
        a_slice  = '0;
        bx_slice = '0;
        for (int i = 0; i < NCH; i++) begin
            if (count_q == CNT_W'(i)) begin
                a_slice  = a_q[i*CHUNK +: CHUNK];
                bx_slice = bx_q[i*CHUNK +: CHUNK];
            end
        end

        sum = {1'b0, a_slice} + {1'b0, bx_slice} + {{CHUNK{1'b0}}, carry_q};

        s_d = s_q;
        for (int i = 0; i < NCH; i++) begin
            if (count_q == CNT_W'(i)) s_d[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        // Subtraction is a + ~b + carry; the initial carry is
                        // 0 for ADD, 1 for SUB and c_in for ADC/SBC.
                        bx_q    <= op[1] ? ~b : b;
                        carry_q <= op[0] ? c_in : op[1];
                        count_q <= '0;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= sum[CHUNK];
                    count_q <= last ? '0 : count_q + CNT_W'(1);
                    if (last) begin
                        // Flags use the fully assembled result, including
                        // the chunk written on this edge.
                        n_q <= s_d[WIDTH-1];
                        z_q <= (s_d == '0);
                        c_q <= sum[CHUNK];
                        v_q <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                               (s_d[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s = s_q;
    assign n = n_q;
    assign z = z_q;
    assign c = c_q;
    assign v = v_q;

endmodule

// File: tb/tb_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial
//
// Bench for addsub_serial with three configurations: 32/8, 32/32 and 16/4.
// One DUT is selected at a time. Directed cases use constant expectations,
// and random cases use an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_addsub_serial;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, c_in;
    logic [1:0]  op;
    logic [31:0] a, b;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    int cur_w    = 32;
    int cur_nch  = 4;

    logic        iv0, iv1, iv2;
    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [31:0] s0, s1;
    logic [15:0] s2;
    logic [3:0]  f0, f1, f2;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    addsub_serial #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .a(a), .b(b), .c_in(c_in), .op(op),
        .out_valid(ov0), .out_ready(out_ready), .s(s0),
        .n(f0[3]), .z(f0[2]), .c(f0[1]), .v(f0[0]));

    addsub_serial #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .c_in(c_in), .op(op),
        .out_valid(ov1), .out_ready(out_ready), .s(s1),
        .n(f1[3]), .z(f1[2]), .c(f1[1]), .v(f1[0]));

    addsub_serial #(.WIDTH(16), .CHUNK(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .op(op),
        .out_valid(ov2), .out_ready(out_ready), .s(s2),
        .n(f2[3]), .z(f2[2]), .c(f2[1]), .v(f2[0]));

    logic        o_ir, o_ov;
    logic [31:0] o_s;
    logic [3:0]  o_f;

    always_comb begin
        o_ir = ir0; o_ov = ov0; o_s = s0; o_f = f0;
        case (sel)
            1: begin o_ir = ir1; o_ov = ov1; o_s = s1;           o_f = f1; end
            2: begin o_ir = ir2; o_ov = ov2; o_s = {16'h0, s2};  o_f = f2; end
            default: ;
        endcase
    end

    // Reference: result and flags from integer arithmetic on w-bit values.
    // Returns {s[31:0], n, z, c, v}.
    function automatic logic [35:0] ref_op(input int w, input logic [1:0] opx,
                                           input logic [31:0] ax, input logic [31:0] bx_in,
                                           input logic ci);
        longint unsigned mask, ua, ub, ubx, cin0, full, sres, uhalf;
        longint          sa, sb, ssum, half;
        logic            rn, rz, rc, rv;
        mask  = (64'd1 << w) - 64'd1;
        uhalf = 64'd1 << (w - 1);
        half  = longint'(uhalf);
        ua    = {32'h0, ax} & mask;
        ub    = {32'h0, bx_in} & mask;
        case (opx)
            2'b00:   begin ubx = ub;        cin0 = 0;  end
            2'b01:   begin ubx = ub;        cin0 = {63'h0, ci}; end
            2'b10:   begin ubx = mask - ub; cin0 = 1;  end
            default: begin ubx = mask - ub; cin0 = {63'h0, ci}; end
        endcase
        full = ua + ubx + cin0;
        sres = full & mask;
        sa = longint'(ua);  if (sa >= half) sa = sa - 2 * half;
        sb = longint'(ubx); if (sb >= half) sb = sb - 2 * half;
        ssum = sa + sb + longint'(cin0);
        rn = (sres >= uhalf);
        rz = (sres == 0);
        rc = (full > mask);
        rv = (ssum >= half) || (ssum < -half);
        return {sres[31:0], rn, rz, rc, rv};
    endfunction

    task automatic set_cfg(input int cfg);
        @(negedge clk);
        sel     = cfg;
        cur_w   = (cfg == 2) ? 16 : 32;
        cur_nch = (cfg == 1) ? 1 : 4;
    endtask

    task automatic scramble();
        a    = $urandom;
        b    = $urandom;
        op   = 2'($urandom_range(0, 3));
        c_in = 1'($urandom_range(0, 1));
    endtask

    // One operation: accept, check latency, result, flags, optional
    // backpressure hold with inputs toggling, then release.
    task automatic do_op(input string name, input logic [1:0] op_i,
                         input logic [31:0] a_i, input logic [31:0] b_i, input logic ci,
                         input logic [31:0] exp_s, input logic [3:0] exp_f, input int hold);
        int k;
        bit seen;
        @(negedge clk);
        checks++;
        if (o_ir !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, o_ir);
        end
        op = op_i; a = a_i; b = b_i; c_in = ci; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        k = 0;
        seen = 0;
        while (!seen && k < 32) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (o_ov === 1'b1) seen = 1;
            else begin
                scramble();
                in_valid = 1'($urandom_range(0, 1));
            end
        end
        checks++;
        if (!seen || k != cur_nch) begin
            failures++;
            $display("FAIL %s latency: got %0d edges (seen=%0d) want %0d", name, k, seen, cur_nch);
        end
        if (seen) begin
            checks++;
            if (o_s !== exp_s) begin
                failures++;
                $display("FAIL %s result: got %h want %h", name, o_s, exp_s);
            end
            checks++;
            if (o_f !== exp_f) begin
                failures++;
                $display("FAIL %s flags_nzcv: got %b want %b", name, o_f, exp_f);
            end
            checks++;
            if (o_ir !== 1'b0) begin
                failures++;
                $display("FAIL %s ready_in_done: got %b want 0", name, o_ir);
            end
            for (int i = 0; i < hold; i++) begin
                scramble();
                in_valid = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (o_ov !== 1'b1 || o_ir !== 1'b0 || o_s !== exp_s || o_f !== exp_f) begin
                    failures++;
                    $display("FAIL %s hold%0d: got ov=%b ir=%b s=%h f=%b want ov=1 ir=0 s=%h f=%b",
                             name, i, o_ov, o_ir, o_s, o_f, exp_s, exp_f);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (o_ov !== 1'b0 || o_ir !== 1'b1) begin
            failures++;
            $display("FAIL %s release: got ov=%b ir=%b want ov=0 ir=1", name, o_ov, o_ir);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int cfg = 0; cfg < 3; cfg++) begin
            sel = cfg;
            #1;
            checks++;
            if (o_ir !== 1'b1 || o_ov !== 1'b0 || o_s !== 32'h0 || o_f !== 4'b0000) begin
                failures++;
                $display("FAIL reset_state cfg%0d: got ir=%b ov=%b s=%h f=%b want ir=1 ov=0 s=0 f=0000",
                         cfg, o_ir, o_ov, o_s, o_f);
            end
        end
        sel = 0;
    endtask

    task automatic test_arith_32();
        do_op("add_wrap",   2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110, 0);
        do_op("sub_5_7",    2'b10, 32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 4'b1000, 0);
        do_op("sub_7_5",    2'b10, 32'd7,         32'd5,         1'b0, 32'h0000_0002, 4'b0010, 0);
        do_op("adc_ovf",    2'b01, 32'h7FFF_FFFF, 32'h0,         1'b1, 32'h8000_0000, 4'b1001, 0);
        do_op("add_no_cin", 2'b00, 32'h7FFF_FFFF, 32'h0,         1'b1, 32'h7FFF_FFFF, 4'b0000, 0);
        do_op("sbc_cin1",   2'b11, 32'h8000_0000, 32'h1,         1'b1, 32'h7FFF_FFFF, 4'b0011, 0);
        do_op("sbc_cin0",   2'b11, 32'h8000_0000, 32'h1,         1'b0, 32'h7FFF_FFFE, 4'b0011, 0);
    endtask

    task automatic test_back_to_back();
        do_op("bp_adc",  2'b01, 32'h7FFF_FFFF, 32'h0,         1'b1, 32'h8000_0000, 4'b1001, 5);
        do_op("b2b_add", 2'b00, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 4'b0000, 0);
        do_op("b2b_sub", 2'b10, 32'h0000_0010, 32'h0000_0010, 1'b0, 32'h0000_0000, 4'b0110, 2);
    endtask

    task automatic test_reset_mid_run();
        // Leave nonzero flags behind so the reset must clear them.
        do_op("pre_rst", 2'b01, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 4'b1001, 0);
        @(negedge clk);
        op = 2'b00; a = 32'h1234_5678; b = 32'h1111_1111; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);              // accept, count=0
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);   // two RUN edges, count=2
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (o_ov !== 1'b0 || o_ir !== 1'b1 || o_s !== 32'h0 || o_f !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_run: got ov=%b ir=%b s=%h f=%b want ov=0 ir=1 s=0 f=0000",
                     o_ov, o_ir, o_s, o_f);
        end
        do_op("post_rst_add", 2'b00, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 4'b0000, 0);
    endtask

    task automatic test_random(input string name, input int count);
        logic [35:0] r;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic        rc;
        for (int i = 0; i < count; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = ra;                // exercises z on SUB
            rc = 1'($urandom_range(0, 1));
            r  = ref_op(cur_w, ro, ra, rb, rc);
            do_op(name, ro, ra, rb, rc, r[35:4], r[3:0], $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        set_cfg(0);
        test_arith_32();
        test_back_to_back();
        test_reset_mid_run();
        test_random("rand_32x8", 25);

        set_cfg(1);
        test_arith_32();
        test_random("rand_32x32", 20);

        set_cfg(2);
        do_op("add16_wrap", 2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110, 0);
        do_op("sub16_neg",  2'b10, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_FFFE, 4'b1000, 0);
        test_random("rand_16x4", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle add/subtract unit supporting ADD, ADC, SUB and SBC on WIDTH-bit operands. It processes CHUNK bits per clock with a registered inter-chunk carry, trading latency for a short carry chain. It returns the result with ARM-style N/Z/C/V flags. It sits in the ALU datapath as the successor to the single-cycle 32-bit ripple ADD/ADCS/SUBS unit and adds valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, operand and result width.
- CHUNK, 8, bits processed per cycle.
  - WIDTH % CHUNK must be 0; any other value is an elaboration error.
  - NCH = WIDTH/CHUNK.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- c_in  in  1  carry input; used by ADC and SBC only.
- op  in  2  operation select: 00 ADD, 01 ADC, 10 SUB, 11 SBC.
- out_valid  out  1  s and flags are valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  result.
- n, z, c, v  out  1 each  negative, zero, carry, overflow flags.

## Operation
- Effective operands and carry:
  - bx = op[1] ? ~b : b.
  - c0 per op: ADD 0, ADC c_in, SUB 1, SBC c_in.
  - Result: s = a + bx + c0, modulo 2^WIDTH.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready, latch a, bx and c0; set carry register = c0 and count = 0; go to RUN.
  - RUN: in_ready=0. Each edge:
    - Compute slice [count*CHUNK +: CHUNK] = a_slice + bx_slice + carry.
    - Write the slice into s; store the CHUNK-bit adder carry-out into the carry register.
    - Increment count.
    - When count == NCH-1 on that edge, go to DONE instead.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE. s and flags are held until then.
- Inputs are ignored outside IDLE, including in_valid.
- Flags are registered, updated on the final RUN edge and valid with out_valid:
  - n = s[WIDTH-1].
  - z = (s == 0).
  - c = final carry-out. For SUB/SBC, c=1 means no borrow.
  - v = (a[WIDTH-1] == bx[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]).
- CHUNK == WIDTH is legal: NCH=1, and RUN lasts one edge.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - s = 0, n = z = c = v = 0, count = 0, carry register = 0.
- Reset mid-operation (RUN or DONE): on the next edge the block returns to reset values and abandons the operation; no partial result is presented.
- Latency: accept on edge T; out_valid is high from the cycle after edge T+NCH (NCH RUN edges). For WIDTH=32, CHUNK=8 that is 4 edges after accept.
- Throughput: at most one operation per NCH+2 cycles (IDLE accept, NCH RUN, at least one DONE cycle).
- in_ready and out_valid are never high in the same cycle.
- Outputs are registered; there is no combinational path from inputs to outputs except in_ready, which depends on state only.
- s bits of chunks not yet computed hold their previous value during RUN and are undefined to consumers until out_valid.
- Operands may change after the accept edge without affecting the result.

## Test plan
Default parameters unless stated otherwise.
- ADD a=0xFFFFFFFF, b=0x00000001 -> s=0x00000000, z=1, c=1, n=0, v=0; out_valid asserted exactly 4 edges after accept.
- SUB a=5, b=7 -> s=0xFFFFFFFE, n=1, c=0, z=0, v=0. SUB a=7, b=5 -> s=2, c=1.
- ADC a=0x7FFFFFFF, b=0, c_in=1 -> s=0x80000000, n=1, v=1, c=0. ADD with the same operands and c_in=1 -> s=0x7FFFFFFF, showing c_in is ignored.
- SBC a=0x80000000, b=1, c_in=1 -> s=0x7FFFFFFF, v=1, c=1. SBC with c_in=0 -> s=0x7FFFFFFE.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid and all inputs. Required: s and flags stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE next edge, and the next operation is accepted.
- Assert rst during RUN at count=2 -> next edge: out_valid=0, in_ready=1, s=0, flags 0. A following ADD 0x12345678 + 0x11111111 -> s=0x23456789. Repeat the arithmetic cases with CHUNK=32 (latency 1) and with WIDTH=16, CHUNK=4 (latency 4; ADD 0xFFFF + 1 -> s=0, c=1, z=1).
